// File: rtl/vedic_seq_mult_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier. A single 2x2 vedic cell is
// stepped over every digit pair (i outer, j inner), and the shifted 4-bit
// partial products are summed into a 2*WIDTH accumulator. Operands come in
// and the product goes out over valid/ready handshakes.

// 2x2 vedic cell: crosswise-vertical partial products plus a half-adder chain.
module vedic2x2_cell (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic w_p00, w_p01, w_p10, w_p11, w_c1;

  assign w_p00 = i_a[0] & i_b[0];
  assign w_p10 = i_a[1] & i_b[0];
  assign w_p01 = i_a[0] & i_b[1];
  assign w_p11 = i_a[1] & i_b[1];
  assign w_c1  = w_p10 & w_p01;

  assign o_p = {w_p11 & w_c1, w_p11 ^ w_c1, w_p10 ^ w_p01, w_p00};
endmodule

module vedic_seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_abort,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_busy
);
  // D digits per operand; counters need at least one bit even when D == 1.
  localparam int D  = WIDTH / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_i, r_j;
  logic            r_out_valid;
  logic [PW-1:0]   r_product;

  logic [1:0]      w_a_dig, w_b_dig;
  logic [3:0]      w_pp;
  logic [CW:0]     w_dsum;
  logic [PW-1:0]   w_pp_ext, w_term, w_sum;
  logic            w_i_last, w_j_last;

  // Current digit pair; the index is simply 2*i / 2*j.
  assign w_a_dig = r_a[{r_i, 1'b0} +: 2];
  assign w_b_dig = r_b[{r_j, 1'b0} +: 2];

  vedic2x2_cell u_cell (
    .i_a (w_a_dig),
    .i_b (w_b_dig),
    .o_p (w_pp)
  );

  // Partial product weighted by 4^(i+j), folded into the running sum.
  assign w_dsum   = {1'b0, r_i} + {1'b0, r_j};
  assign w_pp_ext = PW'(w_pp);
  assign w_term   = w_pp_ext << {w_dsum, 1'b0};
  assign w_sum    = r_acc + w_term;

  assign w_i_last = (r_i == CW'(D - 1));
  assign w_j_last = (r_j == CW'(D - 1));

  // Abort blocks acceptance in the same cycle, so in_ready has to see it.
  assign o_in_ready  = (r_state == S_IDLE) && !i_abort;
  assign o_out_valid = r_out_valid;
  assign o_product   = r_product;
  assign o_busy      = (r_state != S_IDLE);

  // Control FSM plus datapath registers; abort outranks every state action.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
    end else if (i_abort) begin
      // product is intentionally left alone so the last result stays visible.
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          if (w_i_last && w_j_last) begin
            // Final pair goes straight into product; no extra drain cycle.
            r_product   <= w_sum;
            r_out_valid <= 1'b1;
            r_i         <= '0;
            r_j         <= '0;
            r_state     <= S_DONE;
          end else if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + CW'(1);
          end else begin
            r_j <= r_j + CW'(1);
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Bench for vedic_seq_mult_ctrl: WIDTH=8 instance against a latency-count
// model checked every cycle, plus a WIDTH=2 instance swept exhaustively.
module tb_vedic_seq_mult_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        in_valid = 0, abort = 0, out_ready = 0;
  logic [7:0]  a = 0, b = 0;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;

  vedic_seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_abort(abort), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_product(product), .o_busy(busy));

  // WIDTH=2 instance
  logic       c_in_valid = 0, c_out_ready = 1;
  logic [1:0] c_a = 0, c_b = 0;
  logic       c_in_ready, c_out_valid, c_busy;
  logic [3:0] c_product;

  vedic_seq_mult_ctrl #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(c_in_valid), .o_in_ready(c_in_ready),
    .i_a(c_a), .i_b(c_b), .i_abort(1'b0), .o_out_valid(c_out_valid),
    .i_out_ready(c_out_ready), .o_product(c_product), .o_busy(c_busy));

  int n_pass = 0, n_chk = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Model: a job is accepted when idle, completes 16 cycles later with a*b,
  // then waits for out_ready. Abort drops everything but the last product.
  logic        m_busy, m_ovalid;
  int          m_cnt;
  logic [15:0] m_exp, m_prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_ovalid <= 0; m_cnt <= 0; m_exp <= 0; m_prod <= 0;
    end else if (abort) begin
      m_busy <= 0; m_ovalid <= 0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1; m_cnt <= 16; m_exp <= 16'(int'(a) * int'(b));
      end
    end else if (!m_ovalid) begin
      if (m_cnt == 1) begin
        m_ovalid <= 1; m_prod <= m_exp;
      end
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_ovalid <= 0; m_busy <= 0;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_out_valid", out_valid, m_ovalid);
    chk("cyc_busy", busy, m_busy);
    chk("cyc_in_ready", in_ready, !m_busy && !abort);
    chk("cyc_product", product, m_prod);
  end

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ordy);
    @(posedge clk); #1;
    in_valid = 1; a = ta; b = tb; out_ready = ordy;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    lat--;  // edges after the accept edge
  endtask

  // start_op leaves us 1ns after the accept edge, so the first loop edge is T+1.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input int expp, input int hold);
    int lat;
    start_op(ta, tb, hold == 0);
    chk("op_busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("op_latency", lat, 16);
    chk("op_product", product, expp);
    if (hold > 0) begin
      repeat (hold) begin
        chk("hold_in_ready", in_ready, 0);
        in_valid = 1; a = 8'hAA; b = 8'h55;
        @(posedge clk); #1;
        chk("hold_out_valid", out_valid, 1);
        chk("hold_product", product, expp);
      end
      in_valid = 0; out_ready = 1;
    end
    @(posedge clk); #1;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_product_kept", product, expp);
  endtask

  initial begin
    int seen;
    int lat;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_product", product, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1; rst_n = 1;

    // basic, extremes, zero
    op8(8'd13, 8'd11, 143, 0);
    op8(8'd255, 8'd255, 65025, 0);
    op8(8'd0, 8'd200, 0, 0);
    // backpressure
    op8(8'd100, 8'd3, 300, 5);

    // abort at RUN cycle 7
    start_op(8'd200, 8'd200, 1);
    repeat (6) @(posedge clk);
    #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    op8(8'd6, 8'd7, 42, 0);

    // async reset mid-RUN
    start_op(8'd50, 8'd50, 1);
    repeat (5) @(posedge clk);
    #2; rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_product", product, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1;
    op8(8'd9, 8'd9, 81, 0);

    // abort in DONE together with out_ready: result dropped, product kept
    start_op(8'd12, 8'd12, 0);
    wait_valid(lat);
    chk("done_abort_latency", lat, 16);
    abort = 1; out_ready = 1;
    @(posedge clk); #1; abort = 0;
    chk("done_abort_out_valid", out_valid, 0);
    chk("done_abort_busy", busy, 0);
    chk("done_abort_product", product, 144);

    // abort in IDLE with in_valid: not accepted
    in_valid = 1; abort = 1; a = 8'd5; b = 8'd5;
    chk("idle_abort_in_ready", in_ready, 0);
    @(posedge clk); #1; in_valid = 0; abort = 0;
    chk("idle_abort_busy", busy, 0);

    // WIDTH=2: one RUN cycle, exhaustive
    for (int x = 3; x >= 0; x--) begin
      for (int y = 3; y >= 0; y--) begin
        @(posedge clk); #1;
        c_in_valid = 1; c_a = 2'(x); c_b = 2'(y);
        @(posedge clk); #1;
        c_in_valid = 0;
        chk("w2_busy_run", c_busy, 1);
        chk("w2_early_valid", c_out_valid, 0);
        @(posedge clk); #1;
        chk("w2_out_valid", c_out_valid, 1);
        chk("w2_product", c_product, x * y);
        if (x == 3 && y == 3) chk("w2_3x3", c_product, 9);
        @(posedge clk); #1;
        chk("w2_post_valid", c_out_valid, 0);
        chk("w2_in_ready", c_in_ready, 1);
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
